// File: rtl/rand_pq_pkg.sv
// rand_pq_pkg: shared types and constants for the LFSR-driven priority-queue stimulus block.
// Contents: FSM state enum, key/LFSR widths, key and counter types, saturating increment.
// Used by rand_pq_stim and pq_order_chk via import rand_pq_pkg::*.
package rand_pq_pkg;

  localparam int LFSR_W = 8;
  localparam int KEY_W  = 2 * LFSR_W;
  localparam int CNT_W  = 8;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN_HI,
    GEN_LO,
    ENQ,
    DRAIN,
    CHECK,
    DONE
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pq_order_chk.sv
// pq_order_chk: tracks the previously dequeued key and flags any key larger than its predecessor.
// Latency: order_err_o rises on the clock edge that samples the offending key; sticky until clr_i or rst.
// Backpressure: none; samples only when smp_i is high.
// Ports: clk, rst (async, active high), clr_i (start of run), smp_i (key_i valid), key_i, order_err_o.
module pq_order_chk
  import rand_pq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             smp_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             order_err_o
);

  key_t prev_q;
  logic prev_vld_q;
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (clr_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (smp_i) begin
      // The first key of a run has no predecessor; equal keys are legal.
      if (prev_vld_q && (key_i > prev_q)) begin
        err_q <= 1'b1;
      end
      prev_q     <= key_i;
      prev_vld_q <= 1'b1;
    end
  end

  assign order_err_o = err_q;

endmodule

// File: rtl/rand_pq_stim.sv
// rand_pq_stim: packs two LFSR bytes per key, enqueues NUM_OPS keys into a max-first PQ, drains and checks order.
// Latency: at least 3 cycles per enqueue (GEN_HI, GEN_LO, ENQ) and 2 per dequeue (DRAIN, CHECK).
// Backpressure: enq/deq fire only with pq_ready; while waiting key_in holds and the LFSR is frozen.
// Ports: clk, rst (async, active high), start; lfsr_q in / lfsr_enb out; pq_ready, pq_full, pq_empty,
//        pq_key_out in; enq, deq, key_in out; status busy, done, order_err, enq_count, deq_count.
module rand_pq_stim #(
  parameter int NUM_OPS = 16,  // 1..255
  parameter int KEY_W   = 16   // must stay 2 x LFSR width
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [rand_pq_pkg::LFSR_W-1:0] lfsr_q,
  output logic                           lfsr_enb,
  input  logic                           pq_ready,
  input  logic                           pq_full,
  input  logic                           pq_empty,
  input  logic [KEY_W-1:0]               pq_key_out,
  output logic                           enq,
  output logic                           deq,
  output logic [KEY_W-1:0]               key_in,
  output logic                           busy,
  output logic                           done,
  output logic                           order_err,
  output logic [7:0]                     enq_count,
  output logic [7:0]                     deq_count
);

  import rand_pq_pkg::*;

  localparam cnt_t NUM_OPS_C = cnt_t'(NUM_OPS);

  state_t state_q;
  key_t   key_q;
  cnt_t   enq_cnt_q;
  cnt_t   deq_cnt_q;
  logic   busy_q;
  logic   done_q;

  logic   start_acc;
  logic   enq_fire;
  logic   deq_fire;
  cnt_t   enq_cnt_d;
  cnt_t   deq_cnt_d;

  // A start is honoured only when no run is in flight.
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  // Full/empty take priority over ready so no op is issued to a PQ that cannot take it.
  assign enq_fire  = (state_q == ENQ)   && !pq_full  && pq_ready;
  assign deq_fire  = (state_q == DRAIN) && !pq_empty && pq_ready;

  assign enq_cnt_d = sat_inc(enq_cnt_q);
  assign deq_cnt_d = sat_inc(deq_cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      enq_cnt_q <= '0;
      deq_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_acc) begin
            state_q   <= GEN_HI;
            enq_cnt_q <= '0;
            deq_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        GEN_HI: begin
          key_q[KEY_W-1:LFSR_W] <= lfsr_q;
          state_q               <= GEN_LO;
        end

        // The LFSR advanced on the GEN_HI edge, so this is the next state of the sequence.
        GEN_LO: begin
          key_q[LFSR_W-1:0] <= lfsr_q;
          state_q           <= ENQ;
        end

        ENQ: begin
          if (pq_full) begin
            // Running out of PQ space just ends loading early; not an error.
            state_q <= DRAIN;
          end else if (pq_ready) begin
            enq_cnt_q <= enq_cnt_d;
            state_q   <= (enq_cnt_d == NUM_OPS_C) ? DRAIN : GEN_HI;
          end
        end

        DRAIN: begin
          if (pq_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (pq_ready) begin
            deq_cnt_q <= deq_cnt_d;
            state_q   <= CHECK;
          end
        end

        // pq_key_out is valid here; the order checker samples it on this edge.
        CHECK: begin
          state_q <= DRAIN;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  pq_order_chk u_order_chk (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_acc),
    .smp_i       (state_q == CHECK),
    .key_i       (pq_key_out),
    .order_err_o (order_err)
  );

  // Strobes are decoded from the registered state so they line up with the PQ's pq_ready cycle.
  assign lfsr_enb  = (state_q == GEN_HI) || (state_q == GEN_LO);
  assign enq       = enq_fire;
  assign deq       = deq_fire;
  assign key_in    = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign enq_count = enq_cnt_q;
  assign deq_count = deq_cnt_q;

  enq_deq_excl_a : assert property (@(posedge clk) disable iff (rst) !(enq && deq));

endmodule

// File: tb/tb_rand_pq_stim.sv
module tb_rand_pq_stim;

  localparam int NUM_OPS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  lfsr_q;
  logic        lfsr_enb;
  logic        pq_ready;
  logic        pq_full;
  logic        pq_empty;
  logic [15:0] pq_key_out;
  logic        enq;
  logic        deq;
  logic [15:0] key_in;
  logic        busy;
  logic        done;
  logic        order_err;
  logic [7:0]  enq_count;
  logic [7:0]  deq_count;

  always #5 clk = ~clk;

  rand_pq_stim #(.NUM_OPS(NUM_OPS), .KEY_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lfsr_q     (lfsr_q),
    .lfsr_enb   (lfsr_enb),
    .pq_ready   (pq_ready),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .pq_key_out (pq_key_out),
    .enq        (enq),
    .deq        (deq),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .order_err  (order_err),
    .enq_count  (enq_count),
    .deq_count  (deq_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- environment: byte source + behavioural max-first PQ ----------------
  logic [7:0]  src [64];
  int          src_idx;
  logic [15:0] pq_q [$];
  int          cap;
  int          rdy_pct;
  bit          force_lo;
  bit          fault;
  logic [15:0] fault_keys [$];
  logic [15:0] pending_key;
  logic [15:0] enq_seen [$];
  logic [15:0] deq_seen [$];
  logic        err_after [$];
  int          enb_total;
  bit          chk_pend, chk_seen;
  logic        s_done, s_enq, s_enb;
  logic [15:0] s_key;

  // One clock cycle: drive inputs at negedge, sample just after, update model, return 1 after posedge.
  task automatic step();
    int mi;
    @(negedge clk);
    lfsr_q   = (src_idx < 64) ? src[src_idx] : 8'h00;
    pq_full  = (pq_q.size() >= cap);
    pq_empty = (pq_q.size() == 0);
    pq_ready = force_lo ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
    #1;
    check("enq_deq_exclusive", {31'b0, enq & deq}, 32'd0);
    s_done = done;
    s_enq  = enq;
    s_enb  = lfsr_enb;
    s_key  = key_in;
    if (chk_seen) begin
      err_after.push_back(order_err);
      chk_seen = 1'b0;
    end
    if (chk_pend) begin
      chk_seen = 1'b1;
      chk_pend = 1'b0;
    end
    if (lfsr_enb) begin
      enb_total++;
      src_idx++;
    end
    if (enq) begin
      enq_seen.push_back(key_in);
      pq_q.push_back(key_in);
    end
    if (deq && pq_q.size() > 0) begin
      mi = 0;
      foreach (pq_q[i]) if (pq_q[i] > pq_q[mi]) mi = i;
      pending_key = (fault && fault_keys.size() > 0) ? fault_keys.pop_front() : pq_q[mi];
      pq_q.delete(mi);
      deq_seen.push_back(pending_key);
      chk_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    pq_key_out = pending_key;
  endtask

  task automatic begin_run(input int c, input int pct);
    cap       = c;
    rdy_pct   = pct;
    src_idx   = 0;
    enb_total = 0;
    enq_seen.delete();
    deq_seen.delete();
    err_after.delete();
    chk_pend  = 1'b0;
    chk_seen  = 1'b0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    s_done    = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (!s_done && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_reached_done"}, {31'b0, s_done}, 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          cap;
    int          rdy_pct;
    int          nfix;
    logic [15:0] k0, k1, k2, k3;
    int          exp_enq;
  } vec_t;

  function automatic vec_t mkvec(input int c, input int p, input int nf,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] d, input logic [15:0] e, input int x);
    vec_t v;
    v.cap = c; v.rdy_pct = p; v.nfix = nf;
    v.k0 = a; v.k1 = b; v.k2 = d; v.k3 = e; v.exp_enq = x;
    return v;
  endfunction

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fk [4];
    logic [15:0] exp_keys [$];
    logic [15:0] tmp;
    int          exp_n, exp_enb, n;

    tbl[0] = mkvec(4,   100, 4, 16'h0005, 16'hFFFF, 16'h1234, 16'h0005, 4);
    tbl[1] = mkvec(1,   100, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1);
    tbl[2] = mkvec(100, 100, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, NUM_OPS);
    tbl[3] = mkvec(3,   60,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3);
    tbl[4] = mkvec(100, 40,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, NUM_OPS);
    tbl[5] = mkvec(16,  100, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, NUM_OPS);

    rst = 1'b1; start = 1'b0; lfsr_q = '0; pq_ready = 1'b0; pq_full = 1'b0;
    pq_empty = 1'b1; pq_key_out = '0; pending_key = '0;
    cap = 100; rdy_pct = 100; force_lo = 1'b0; fault = 1'b0; src_idx = 0;
    for (int i = 0; i < 64; i++) src[i] = '0;

    // ---- reset state ----
    #3;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_order_err", {31'b0, order_err}, 0);
    check("rst_key_in", {16'b0, key_in}, 0);
    check("rst_enq_count", {24'b0, enq_count}, 0);
    check("rst_deq_count", {24'b0, deq_count}, 0);
    check("rst_strobes", {29'b0, enq, deq, lfsr_enb}, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // ---- table-driven runs ----
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].nfix > 0) begin
        for (int i = 0; i < 64; i++) src[i] = '0;
        fk[0] = tbl[r].k0; fk[1] = tbl[r].k1; fk[2] = tbl[r].k2; fk[3] = tbl[r].k3;
        for (int j = 0; j < tbl[r].nfix; j++) begin
          src[2*j]   = fk[j][15:8];
          src[2*j+1] = fk[j][7:0];
        end
      end else begin
        fill_random();
      end
      begin_run(tbl[r].cap, tbl[r].rdy_pct);
      run_to_done($sformatf("row%0d", r));

      exp_n   = tbl[r].exp_enq;
      exp_enb = (tbl[r].cap < NUM_OPS) ? 2 * (tbl[r].cap + 1) : 2 * NUM_OPS;
      exp_keys.delete();
      for (int j = 0; j < exp_n; j++) exp_keys.push_back({src[2*j], src[2*j+1]});

      check($sformatf("row%0d_enq_events", r), enq_seen.size(), exp_n);
      for (int j = 0; j < exp_n; j++)
        if (j < enq_seen.size())
          check($sformatf("row%0d_key%0d", r, j), {16'b0, enq_seen[j]}, {16'b0, exp_keys[j]});
      check($sformatf("row%0d_enq_count", r), {24'b0, enq_count}, exp_n);
      check($sformatf("row%0d_deq_count", r), {24'b0, deq_count}, exp_n);
      check($sformatf("row%0d_order_err", r), {31'b0, order_err}, 0);
      check($sformatf("row%0d_done", r), {31'b0, done}, 1);
      check($sformatf("row%0d_busy", r), {31'b0, busy}, 0);
      check($sformatf("row%0d_lfsr_enb_cycles", r), enb_total, exp_enb);

      // Expected drain order: the packed keys sorted largest first.
      for (int a = 0; a < exp_n; a++)
        for (int b = a + 1; b < exp_n; b++)
          if (exp_keys[b] > exp_keys[a]) begin
            tmp = exp_keys[a]; exp_keys[a] = exp_keys[b]; exp_keys[b] = tmp;
          end
      check($sformatf("row%0d_deq_events", r), deq_seen.size(), exp_n);
      for (int j = 0; j < exp_n; j++)
        if (j < deq_seen.size())
          check($sformatf("row%0d_drain%0d", r, j), {16'b0, deq_seen[j]}, {16'b0, exp_keys[j]});
    end

    // ---- ordering fault: PQ returns 0x0010 then 0x0020 ----
    fill_random();
    fault = 1'b1;
    fault_keys.delete();
    fault_keys.push_back(16'h0010);
    fault_keys.push_back(16'h0020);
    begin_run(2, 100);
    run_to_done("fault");
    check("fault_check_count", err_after.size(), 2);
    if (err_after.size() == 2) begin
      check("fault_err_after_first", {31'b0, err_after[0]}, 0);
      check("fault_err_after_second", {31'b0, err_after[1]}, 1);
    end
    check("fault_err_at_done", {31'b0, order_err}, 1);
    fault = 1'b0;

    // ---- back-pressure: next start clears order_err; ready held low 5 cycles in ENQ ----
    fill_random();
    force_lo = 1'b1;
    begin_run(100, 100);
    check("err_cleared_by_start", {31'b0, order_err}, 0);
    step(); step();
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp%0d_enq", c), {31'b0, s_enq}, 0);
      check($sformatf("bp%0d_lfsr_enb", c), {31'b0, s_enb}, 0);
      check($sformatf("bp%0d_key_in", c), {16'b0, s_key}, {16'b0, src[0], src[1]});
    end
    force_lo = 1'b0;
    run_to_done("bp");
    check("bp_enq_count", {24'b0, enq_count}, NUM_OPS);
    check("bp_first_key", (enq_seen.size() > 0) ? {16'b0, enq_seen[0]} : 32'hFFFF_FFFF,
          {16'b0, src[0], src[1]});

    // ---- start pulsed during GEN_LO must be ignored ----
    fill_random();
    begin_run(100, 100);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("swb_enq_after_gen_lo", {31'b0, s_enq}, 1);
    check("swb_no_regen", {31'b0, s_enb}, 0);
    run_to_done("swb");
    check("swb_enq_events", enq_seen.size(), NUM_OPS);
    check("swb_enq_count", {24'b0, enq_count}, NUM_OPS);
    check("swb_lfsr_enb_cycles", enb_total, 2 * NUM_OPS);

    // ---- asynchronous reset in the middle of DRAIN ----
    fill_random();
    begin_run(100, 100);
    n = 0;
    while (deq_seen.size() < 2 && n < 500) begin
      step();
      n++;
    end
    check("rstd_reached_drain", deq_seen.size(), 2);
    step();
    check("rstd_pre_deq", {31'b0, deq}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstd_deq", {31'b0, deq}, 0);
    check("rstd_enq", {31'b0, enq}, 0);
    check("rstd_busy", {31'b0, busy}, 0);
    check("rstd_done", {31'b0, done}, 0);
    check("rstd_enq_count", {24'b0, enq_count}, 0);
    check("rstd_deq_count", {24'b0, deq_count}, 0);
    check("rstd_key_in", {16'b0, key_in}, 0);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstd_start_ignored", {30'b0, busy, lfsr_enb}, 0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    pq_q.delete();
    step();
    check("rstd_idle_after_release", {29'b0, busy, s_enq, s_enb}, 0);

    // ---- recovery run after reset ----
    fill_random();
    begin_run(2, 100);
    run_to_done("recover");
    check("recover_enq_count", {24'b0, enq_count}, 2);
    check("recover_deq_count", {24'b0, deq_count}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
